// File: rtl/biquad_cascade_sched_pkg.sv
// Shared constants, types and helpers for the biquad cascade scheduler.
package biquad_cascade_sched_pkg;

    // Coefficient slot order within one section's five-word config block.
    localparam int NUM_COEF = 5;
    typedef logic [2:0] coef_idx_t;
    localparam coef_idx_t IDX_B0 = 3'd0;
    localparam coef_idx_t IDX_B1 = 3'd1;
    localparam coef_idx_t IDX_B2 = 3'd2;
    localparam coef_idx_t IDX_A1 = 3'd3;
    localparam coef_idx_t IDX_A2 = 3'd4;

    // Coefficients are Q2.14, so products are rescaled by 14 bits.
    localparam int Q_SHIFT = 14;

    // b0 = 1.0 in Q2.14; the identity section passes samples straight through.
    localparam int B0_IDENTITY = 16384;

    // Filter state is held at 40 bits and wraps on overflow.
    localparam int ST_W = 40;
    typedef logic signed [ST_W-1:0] acc_t;

    // Largest representable sample for a dw-bit signed Q1.(dw-1) value.
    function automatic acc_t sat_hi(input int dw);
        return (acc_t'(1) <<< (dw - 1)) - acc_t'(1);
    endfunction

    // Most negative representable sample for a dw-bit signed value.
    function automatic acc_t sat_lo(input int dw);
        return -(acc_t'(1) <<< (dw - 1));
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OUT
    } state_t;

endpackage

// File: rtl/biquad_cascade_sched_step.sv
// One transposed direct-form-II biquad section, purely combinational.
// Output y is saturated to the sample range and the saturated value drives
// the feedback terms; the two state words wrap at 40 bits.
module biquad_step
    import biquad_cascade_sched_pkg::*;
#(
    parameter int DW = 24,
    parameter int CW = 16
) (
    input  logic signed [DW-1:0] x_i,
    input  acc_t                 s1_i,
    input  acc_t                 s2_i,
    input  logic signed [CW-1:0] b0_i,
    input  logic signed [CW-1:0] b1_i,
    input  logic signed [CW-1:0] b2_i,
    input  logic signed [CW-1:0] a1_i,
    input  logic signed [CW-1:0] a2_i,
    output logic signed [DW-1:0] y_o,
    output acc_t                 s1_o,
    output acc_t                 s2_o
);

    localparam int PW = DW + CW;

    // Full-width product rescaled back to state precision.
    function automatic acc_t scale(input logic signed [PW-1:0] p);
        return acc_t'(p >>> Q_SHIFT);
    endfunction

    logic signed [PW-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
    acc_t                 y_full;
    acc_t                 y_sat;

    assign p_b0 = PW'(b0_i) * PW'(x_i);
    assign p_b1 = PW'(b1_i) * PW'(x_i);
    assign p_b2 = PW'(b2_i) * PW'(x_i);
    assign y_full = scale(p_b0) + s1_i;

    // Clamp the section output into the sample range.
    always_comb begin
        // NOTE: every path assigns y_sat from a default first, so no latch is inferred.
        y_sat = y_full;
        if (y_full > sat_hi(DW)) begin
            y_sat = sat_hi(DW);
        end else if (y_full < sat_lo(DW)) begin
            y_sat = sat_lo(DW);
        end
    end

    assign y_o  = DW'(y_sat);
    assign p_a1 = PW'(a1_i) * PW'(y_o);
    assign p_a2 = PW'(a2_i) * PW'(y_o);
    assign s1_o = scale(p_b1) - scale(p_a1) + s2_i;
    assign s2_o = scale(p_b2) - scale(p_a2);

endmodule

// File: rtl/biquad_cascade_sched.sv
// Time-multiplexed biquad cascade for a stereo pair: one shared section
// evaluates L stages 0..S-1 then R stages 0..S-1, one per clock. A shadow
// coefficient bank is copied to the active bank, and filter state cleared,
// only while idle so a pair never sees a half-updated filter.
module biquad_cascade_sched
    import biquad_cascade_sched_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int DW         = 24,
    parameter int CW         = 16,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [DW-1:0]  in_l,
    input  logic signed [DW-1:0]  in_r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [DW-1:0]  out_l,
    output logic signed [DW-1:0]  out_r,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic signed [CW-1:0]  cfg_data,
    input  logic                  cfg_commit,
    input  logic                  cfg_clear,
    output logic                  commit_pending,
    output logic                  busy
);

    localparam int STG_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CNT_W    = $clog2(2 * NUM_STAGES + 1);
    localparam int NUM_ADDR = NUM_STAGES * NUM_COEF;
    // cnt 0..2S-1 evaluates sections; cnt 2S moves the finished pair out.
    localparam logic [CNT_W-1:0] CNT_R0   = CNT_W'(NUM_STAGES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * NUM_STAGES);

    typedef logic signed [CW-1:0] coef_t;
    typedef coef_t bank_t [NUM_STAGES][NUM_COEF];
    typedef acc_t  state_arr_t [2][NUM_STAGES];
    typedef logic signed [DW-1:0] work_t [2];

    function automatic bank_t identity_bank();
        bank_t b;
        for (int s = 0; s < NUM_STAGES; s++) begin
            for (int k = 0; k < NUM_COEF; k++) begin
                b[s][k] = (k == 0) ? coef_t'(B0_IDENTITY) : coef_t'(0);
            end
        end
        return b;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    bank_t              shadow_q, shadow_d, active_q;
    state_arr_t         s1_q, s2_q;
    work_t              x_q;
    logic signed [DW-1:0] out_l_q, out_r_q;
    logic               commit_pend_q, commit_pend_d;
    logic               clear_pend_q, clear_pend_d;

    logic               accept, computing, finishing;
    logic               apply_commit, apply_clear;
    logic               wr_ok;
    logic [STG_W-1:0]   wr_stg, run_stg;
    coef_idx_t          wr_k;
    logic [0:0]         run_ch;
    logic signed [DW-1:0] step_y;
    acc_t               step_s1, step_s2;

    assign in_ready       = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign out_valid      = (state_q == ST_OUT);
    assign out_l          = out_l_q;
    assign out_r          = out_r_q;
    assign commit_pending = commit_pend_q;

    assign accept       = (state_q == ST_IDLE) && in_valid;
    assign computing    = (state_q == ST_RUN) && (cnt_q < CNT_LAST);
    assign finishing    = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign apply_commit = (state_q == ST_IDLE) && commit_pend_q;
    assign apply_clear  = (state_q == ST_IDLE) && clear_pend_q;

    // Decode the config address and fold this cycle's write into the shadow bank.
    always_comb begin
        wr_ok  = 1'b0;
        wr_stg = '0;
        wr_k   = '0;
        if (int'(cfg_addr) < NUM_ADDR) begin
            wr_ok  = 1'b1;
            wr_stg = STG_W'(int'(cfg_addr) / NUM_COEF);
            wr_k   = coef_idx_t'(int'(cfg_addr) % NUM_COEF);
        end
        shadow_d = shadow_q;
        if (cfg_we && wr_ok) begin
            shadow_d[wr_stg][wr_k] = cfg_data;
        end
    end

    // Map the run counter onto channel and stage.
    always_comb begin
        run_ch  = 1'b0;
        run_stg = '0;
        if (cnt_q < CNT_R0) begin
            run_stg = STG_W'(cnt_q);
        end else if (computing) begin
            run_ch  = 1'b1;
            run_stg = STG_W'(cnt_q - CNT_R0);
        end
    end

    biquad_step #(
        .DW(DW),
        .CW(CW)
    ) u_step (
        .x_i  (x_q[run_ch]),
        .s1_i (s1_q[run_ch][run_stg]),
        .s2_i (s2_q[run_ch][run_stg]),
        .b0_i (active_q[run_stg][IDX_B0]),
        .b1_i (active_q[run_stg][IDX_B1]),
        .b2_i (active_q[run_stg][IDX_B2]),
        .a1_i (active_q[run_stg][IDX_A1]),
        .a2_i (active_q[run_stg][IDX_A2]),
        .y_o  (step_y),
        .s1_o (step_s1),
        .s2_o (step_s2)
    );

    // FSM next state and run counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pending flags: a new request wins over the clear on the apply edge.
    always_comb begin
        commit_pend_d = commit_pend_q;
        clear_pend_d  = clear_pend_q;
        if (apply_commit) commit_pend_d = 1'b0;
        if (apply_clear)  clear_pend_d  = 1'b0;
        if (cfg_commit)   commit_pend_d = 1'b1;
        if (cfg_clear)    clear_pend_d  = 1'b1;
    end

    // Pending-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_pend_q <= 1'b0;
            clear_pend_q  <= 1'b0;
        end else begin
            commit_pend_q <= commit_pend_d;
            clear_pend_q  <= clear_pend_d;
        end
    end

    // Coefficient banks; the active bank only moves while idle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: both banks are reset because the identity filter must be live from reset.
        if (rst) begin
            shadow_q <= identity_bank();
            active_q <= identity_bank();
        end else begin
            shadow_q <= shadow_d;
            if (apply_commit) begin
                active_q <= shadow_d;
            end
        end
    end

    // Sample datapath: work registers, per-channel filter state and output pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '{default: '0};
            s2_q    <= '{default: '0};
            x_q     <= '{default: '0};
            out_l_q <= '0;
            out_r_q <= '0;
        end else begin
            if (apply_clear) begin
                s1_q <= '{default: '0};
                s2_q <= '{default: '0};
            end
            if (accept) begin
                x_q[0] <= in_l;
                x_q[1] <= in_r;
            end
            if (computing) begin
                x_q[run_ch]           <= step_y;
                s1_q[run_ch][run_stg] <= step_s1;
                s2_q[run_ch][run_stg] <= step_s2;
            end
            if (finishing) begin
                out_l_q <= x_q[0];
                out_r_q <= x_q[1];
            end
        end
    end

endmodule

// File: tb/tb_biquad_cascade_sched.sv
// Self-checking bench for biquad_cascade_sched: directed scenarios plus a
// randomized run against a plain-arithmetic model of the filter cascade.
module tb_biquad_cascade_sched;

    localparam int NS = 4;
    localparam int DW = 24;
    localparam int CW = 16;
    localparam int AW = 5;
    localparam int LAT = 2 * NS + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_l, in_r, out_l, out_r;
    logic          cfg_we, cfg_commit, cfg_clear, commit_pending, busy;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    longint m_shadow [NS][5];
    longint m_active [NS][5];
    longint m_s1 [2][NS];
    longint m_s2 [2][NS];

    always #5 clk = ~clk;

    biquad_cascade_sched #(
        .NUM_STAGES(NS), .DW(DW), .CW(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_l(in_l), .in_r(in_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_clear(cfg_clear),
        .commit_pending(commit_pending), .busy(busy)
    );

    function automatic longint wrap40(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    function automatic longint sat24(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < 5; k++) begin
                m_shadow[s][k] = (k == 0) ? 64'sd16384 : 64'sd0;
                m_active[s][k] = m_shadow[s][k];
            end
        end
        model_clear();
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < NS; s++) begin
                m_s1[c][s] = 0;
                m_s2[c][s] = 0;
            end
        end
    endtask

    // Run one stereo pair through the cascade, updating model state.
    task automatic model_pair(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              output logic [DW-1:0] el, output logic [DW-1:0] er);
        longint x, yf, y;
        for (int c = 0; c < 2; c++) begin
            x = (c == 0) ? longint'($signed(l)) : longint'($signed(r));
            for (int s = 0; s < NS; s++) begin
                yf = wrap40(((m_active[s][0] * x) >>> 14) + m_s1[c][s]);
                y  = sat24(yf);
                m_s1[c][s] = wrap40(((m_active[s][1] * x) >>> 14)
                                    - ((m_active[s][3] * y) >>> 14) + m_s2[c][s]);
                m_s2[c][s] = wrap40(((m_active[s][2] * x) >>> 14)
                                    - ((m_active[s][4] * y) >>> 14));
                x = y;
            end
            if (c == 0) el = DW'(x);
            else        er = DW'(x);
        end
    endtask

    task automatic cfg_write(input int addr, input logic [CW-1:0] d, input logic with_commit);
        cfg_we = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = d;
        cfg_commit = with_commit;
        if (addr < NS * 5) m_shadow[addr / 5][addr % 5] = longint'($signed(d));
        @(negedge clk);
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // Commit from IDLE: pending must be high for exactly one cycle.
    task automatic do_commit(input logic also_clear);
        cfg_commit = 1'b1;
        cfg_clear  = also_clear;
        @(negedge clk);
        cfg_commit = 1'b0;
        cfg_clear  = 1'b0;
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL commit_pending_set: got %b expected 1", commit_pending);
        end
        @(negedge clk);
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL commit_pending_clear: got %b expected 0", commit_pending);
        end
        m_active = m_shadow;
        if (also_clear) model_clear();
    endtask

    task automatic accept_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
        end
        in_valid  = 1'b1;
        in_l      = l;
        in_r      = r;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got %b expected 1", out_valid);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic xfer(input logic [DW-1:0] l, input logic [DW-1:0] r,
                        output logic [DW-1:0] ol, output logic [DW-1:0] orr, output int lat);
        accept_pair(l, r);
        wait_valid(lat);
        ol  = out_l;
        orr = out_r;
        handshake();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_l = '0; in_r = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0; cfg_clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got v%b r%b b%b p%b expected v0 r1 b0 p0",
                     out_valid, in_ready, busy, commit_pending);
        end
        checks++;
        if (out_l !== 24'h0 || out_r !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h expected 000000/000000", out_l, out_r);
        end
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] el, er, gl, gr;
        int lat;
        model_pair(24'h100000, 24'hF00000, el, er);
        accept_pair(24'h100000, 24'hF00000);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_flags: got busy %b in_ready %b expected 1 0", busy, in_ready);
        end
        wait_valid(lat);
        gl = out_l; gr = out_r;
        handshake();
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (gl !== 24'h100000 || gr !== 24'hF00000 || gl !== el || gr !== er) begin
            errors++;
            $display("FAIL passthrough: got %h/%h expected 100000/F00000", gl, gr);
        end
    endtask

    task automatic test_gain();
        logic [DW-1:0] el, er, gl, gr;
        int lat;
        cfg_write(0, 16'd8192, 1'b0);
        cfg_write(20, 16'h1234, 1'b0);
        cfg_write(31, 16'h4321, 1'b0);
        do_commit(1'b0);
        model_pair(24'h400000, 24'h400000, el, er);
        xfer(24'h400000, 24'h400000, gl, gr, lat);
        checks++;
        if (gl !== 24'h200000 || gr !== 24'h200000 || gl !== el || gr !== er) begin
            errors++;
            $display("FAIL gain_half: got %h/%h expected 200000/200000", gl, gr);
        end
    endtask

    task automatic test_feedback();
        logic [DW-1:0] el, er, gl, gr;
        logic [DW-1:0] exp_seq [4] = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};
        int lat;
        cfg_write(0, 16'd16384, 1'b0);
        // Write and commit in the same cycle: the write must be part of the copy.
        cfg_write(3, 16'hE000, 1'b1);
        @(negedge clk);
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL we_commit_pending: got %b expected 0", commit_pending);
        end
        m_active = m_shadow;
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
        @(negedge clk);
        model_clear();
        for (int i = 0; i < 4; i++) begin
            model_pair((i == 0) ? 24'h400000 : 24'h0, 24'h0, el, er);
            xfer((i == 0) ? 24'h400000 : 24'h0, 24'h0, gl, gr, lat);
            checks++;
            if (gl !== exp_seq[i] || gl !== el || gr !== 24'h0) begin
                errors++;
                $display("FAIL feedback_%0d: got %h/%h expected %h/000000", i, gl, gr, exp_seq[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] el, er, gl, gr;
        int lat;
        cfg_write(0, 16'd32767, 1'b0);
        cfg_write(3, 16'd0, 1'b0);
        do_commit(1'b1);
        model_pair(24'h7FFFFF, 24'h800000, el, er);
        xfer(24'h7FFFFF, 24'h800000, gl, gr, lat);
        checks++;
        if (gl !== 24'h7FFFFF || gr !== 24'h800000 || gl !== el || gr !== er) begin
            errors++;
            $display("FAIL saturate: got %h/%h expected 7FFFFF/800000", gl, gr);
        end
    endtask

    task automatic test_commit_during_run();
        logic [DW-1:0] el, er, gl, gr;
        int lat;
        cfg_write(0, 16'd16384, 1'b0);
        do_commit(1'b1);
        cfg_write(0, 16'd8192, 1'b0);
        model_pair(24'h200000, 24'h200000, el, er);
        accept_pair(24'h200000, 24'h200000);
        repeat (3) @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        checks++;
        if (commit_pending !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_commit_pending: got p%b b%b expected p1 b1", commit_pending, busy);
        end
        wait_valid(lat);
        gl = out_l; gr = out_r;
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL out_commit_pending: got %b expected 1", commit_pending);
        end
        handshake();
        checks++;
        if (gl !== 24'h200000 || gr !== 24'h200000 || gl !== el || gr !== er) begin
            errors++;
            $display("FAIL run_commit_unchanged: got %h/%h expected 200000/200000", gl, gr);
        end
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL idle_commit_pending: got %b expected 1", commit_pending);
        end
        @(negedge clk);
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL idle_commit_applied: got %b expected 0", commit_pending);
        end
        m_active = m_shadow;
        model_pair(24'h200000, 24'h200000, el, er);
        xfer(24'h200000, 24'h200000, gl, gr, lat);
        checks++;
        if (gl !== 24'h100000 || gr !== 24'h100000 || gl !== el || gr !== er) begin
            errors++;
            $display("FAIL run_commit_next: got %h/%h expected 100000/100000", gl, gr);
        end
    endtask

    task automatic test_commit_with_input();
        logic [DW-1:0] el, er, gl, gr;
        int lat;
        cfg_write(0, 16'd16384, 1'b0);
        cfg_write(5, 16'd8192, 1'b0);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        m_active = m_shadow;
        model_pair(24'h300000, 24'hD00000, el, er);
        accept_pair(24'h300000, 24'hD00000);
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL coincide_pending: got %b expected 0", commit_pending);
        end
        wait_valid(lat);
        gl = out_l; gr = out_r;
        handshake();
        checks++;
        if (gl !== 24'h180000 || gr !== 24'hE80000 || gl !== el || gr !== er) begin
            errors++;
            $display("FAIL coincide_new_coef: got %h/%h expected 180000/E80000", gl, gr);
        end
    endtask

    task automatic test_backpressure_and_reset();
        logic [DW-1:0] el, er, gl, gr;
        int lat;
        model_pair(24'h123456, 24'hABCDEF, el, er);
        accept_pair(24'h123456, 24'hABCDEF);
        wait_valid(lat);
        gl = out_l; gr = out_r;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_l !== gl || out_r !== gr) begin
                errors++;
                $display("FAIL stall_%0d: got v%b r%b %h/%h expected v1 r0 %h/%h",
                         i, out_valid, in_ready, out_l, out_r, gl, gr);
            end
        end
        handshake();
        checks++;
        if (gl !== el || gr !== er) begin
            errors++;
            $display("FAIL stall_data: got %h/%h expected %h/%h", gl, gr, el, er);
        end
        // Reset in the middle of a run with a commit pending.
        cfg_write(0, 16'd4096, 1'b0);
        accept_pair(24'h010101, 24'h020202);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || commit_pending !== 1'b0 || out_l !== 24'h0) begin
            errors++;
            $display("FAIL mid_run_reset: got v%b b%b p%b %h expected v0 b0 p0 000000",
                     out_valid, busy, commit_pending, out_l);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_commit(1'b0);
        model_pair(24'h100000, 24'hF00000, el, er);
        xfer(24'h100000, 24'hF00000, gl, gr, lat);
        checks++;
        if (gl !== 24'h100000 || gr !== 24'hF00000 || gl !== el || gr !== er) begin
            errors++;
            $display("FAIL post_reset_passthrough: got %h/%h expected 100000/F00000", gl, gr);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] el, er, gl, gr, l, r;
        int lat;
        for (int blk = 0; blk < 4; blk++) begin
            for (int w = 0; w < 6; w++) begin
                cfg_write($urandom_range(0, 31), CW'($urandom_range(0, 65535)), 1'b0);
            end
            do_commit(blk[0]);
            for (int i = 0; i < 5; i++) begin
                l = DW'($urandom);
                r = DW'($urandom);
                model_pair(l, r, el, er);
                accept_pair(l, r);
                wait_valid(lat);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                gl = out_l; gr = out_r;
                handshake();
                checks++;
                if (gl !== el || gr !== er || lat !== LAT) begin
                    errors++;
                    $display("FAIL random_%0d_%0d: got %h/%h lat %0d expected %h/%h lat %0d",
                             blk, i, gl, gr, lat, el, er, LAT);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_gain();
        test_feedback();
        test_saturation();
        test_commit_during_run();
        test_commit_with_input();
        test_backpressure_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
